// File: rtl/psi_pkg.sv
// Shared definitions for the PSI MAC accelerator and its APB feeder:
// register offsets and the feeder FSM state encoding.
package psi_pkg;

    localparam logic [11:0] PSI_OFF_INBUFFER  = 12'h000;
    localparam logic [11:0] PSI_OFF_WBUFFER_0 = 12'h004;
    localparam logic [11:0] PSI_OFF_OUT       = 12'h008;

    typedef enum logic [2:0] {
        StIdle,
        StCfgSetup,
        StCfgAccess,
        StWrSetup,
        StWrAccess,
        StRdSetup,
        StRdAccess,
        StOutHold
    } psi_feeder_state_t;

endpackage

// File: rtl/psi_sample_fifo.sv
// Small 8-bit sample FIFO with registered occupancy count; DEPTH must be a power of 2.
module psi_sample_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
            else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/apb_psi_feeder.sv
// APB master feeding samples and tap weights to the PSI MAC accelerator and returning results.
// Build option: define PSI_FEEDER_WARMUP_EN to drop the first two partial-window results after reset.
module apb_psi_feeder
    import psi_pkg::*;
#(
    parameter int unsigned                APB_ADDR_WIDTH = 12,
    parameter int unsigned                FIFO_DEPTH     = 4,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [7:0]                s_data_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [23:0]               w_data_i,
    input  logic                      w_load_i,
    output logic [31:0]               res_data_o,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_IN  = BASE_ADDR + APB_ADDR_WIDTH'(PSI_OFF_INBUFFER);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_W   = BASE_ADDR + APB_ADDR_WIDTH'(PSI_OFF_WBUFFER_0);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_OUT = BASE_ADDR + APB_ADDR_WIDTH'(PSI_OFF_OUT);

    psi_feeder_state_t state;
    logic              pend;
    logic [23:0]       wpend;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_head;
    logic              push;
    logic              pop;
`ifdef PSI_FEEDER_WARMUP_EN
    logic [1:0]        warm_cnt;
`endif

    assign s_ready_o = !fifo_full;
    assign push      = s_valid_i && s_ready_o;
    assign pop       = (state == StWrAccess) && PREADY;

    psi_sample_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (HCLK),
        .rst      (HRESET),
        .push     (push),
        .push_data(s_data_i),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= StIdle;
            pend        <= 1'b0;
            wpend       <= '0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            res_data_o  <= '0;
            res_valid_o <= 1'b0;
            err_o       <= 1'b0;
`ifdef PSI_FEEDER_WARMUP_EN
            warm_cnt    <= '0;
`endif
        end else begin
            if (w_load_i) begin
                pend  <= 1'b1;
                wpend <= w_data_i;
            end
            if (PSEL && PENABLE && PREADY && PSLVERR) err_o <= 1'b1;

            case (state)
                StIdle: begin
                    if (pend) begin
                        state   <= StCfgSetup;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b1;
                        PADDR   <= ADDR_W;
                        // A pulse in this very cycle is the latest value and must win.
                        PWDATA  <= {8'h0, w_load_i ? w_data_i : wpend};
                    end else if (!fifo_empty) begin
                        state   <= StWrSetup;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b1;
                        PADDR   <= ADDR_IN;
                        PWDATA  <= {24'h0, fifo_head};
                    end
                end
                StCfgSetup: begin
                    state   <= StCfgAccess;
                    PENABLE <= 1'b1;
                    if (!w_load_i) pend <= 1'b0;
                end
                StCfgAccess: begin
                    if (PREADY) begin
                        state   <= StIdle;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                    end
                end
                StWrSetup: begin
                    state   <= StWrAccess;
                    PENABLE <= 1'b1;
                end
                StWrAccess: begin
                    if (PREADY) begin
                        state   <= StRdSetup;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        PADDR   <= ADDR_OUT;
                        PWDATA  <= '0;
                    end
                end
                StRdSetup: begin
                    state   <= StRdAccess;
                    PENABLE <= 1'b1;
                end
                StRdAccess: begin
                    if (PREADY) begin
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        res_data_o <= PRDATA;
`ifdef PSI_FEEDER_WARMUP_EN
                        if (warm_cnt < 2'd2) begin
                            warm_cnt <= warm_cnt + 2'd1;
                            state    <= StIdle;
                        end else begin
                            res_valid_o <= 1'b1;
                            state       <= StOutHold;
                        end
`else
                        res_valid_o <= 1'b1;
                        state       <= StOutHold;
`endif
                    end
                end
                StOutHold: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_psi_feeder.sv
// Self-checking bench: APB accelerator model, scoreboard of expected MAC results, directed + random phases.
module tb_apb_psi_feeder;

`ifdef PSI_FEEDER_WARMUP_EN
    localparam int WARM = 2;
`else
    localparam int WARM = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready_o;
    logic [23:0] w_data;
    logic        w_load;
    logic [31:0] res_data_o;
    logic        res_valid_o;
    logic        res_ready;
    logic        err_o;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_psi_feeder #(
        .APB_ADDR_WIDTH(12),
        .FIFO_DEPTH    (4),
        .BASE_ADDR     (12'h000)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready_o),
        .w_data_i   (w_data),
        .w_load_i   (w_load),
        .res_data_o (res_data_o),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready),
        .err_o      (err_o),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Controls written only by the main sequence.
    logic [23:0] mw = '0;
    bit          rr_mode = 0;
    bit          rr_fixed = 1;
    int          max_wait = 0;
    bit          err_rate = 0;
    bit          hold_forever = 0;
    int          wr_wait_force = -1;
    int          err_req = 0;

    // Model state written only by the slave/monitor process.
    logic [7:0]  s_q[$];
    logic [7:0]  hist[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [7:0]  acc_win[3];
    logic [23:0] acc_w;
    bit          in_flight;
    bit          exp_err;
    int          n_acc;
    int          n_reads;
    int          err_done;
    int          cfg_writes = 0;
    int          inbuf_writes = 0;
    int          wait_left;
    logic [11:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_write;
    bit          prev_stall;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event not seen / unexpected event", name);
    endtask

    task automatic apb_complete();
        logic [7:0] es;
        if (cap_write && cap_addr == 12'h004) begin
            check("cfg_between_samples", 32'(in_flight), 32'd0);
            check("cfg_wdata", PWDATA, {8'h0, mw});
            acc_w = PWDATA[23:0];
            cfg_writes++;
        end else if (cap_write && cap_addr == 12'h000) begin
            if (s_q.size() == 0) flag_fail("inbuffer_write_unexpected");
            else begin
                es = s_q.pop_front();
                check("inbuffer_wdata", PWDATA, {24'h0, es});
            end
            acc_win[2] = acc_win[1];
            acc_win[1] = acc_win[0];
            acc_win[0] = PWDATA[7:0];
            in_flight = 1;
            inbuf_writes++;
            if (err_req != err_done) begin
                PSLVERR  = 1'b1;
                err_done = err_req;
            end
        end else if (!cap_write && cap_addr == 12'h008) begin
            check("read_follows_write", 32'(in_flight), 32'd1);
            PRDATA = 32'(acc_w[23:16]) * 32'(acc_win[0]) + 32'(acc_w[15:8]) * 32'(acc_win[1])
                   + 32'(acc_w[7:0]) * 32'(acc_win[2]);
            if (n_reads < WARM) in_flight = 0;
            n_reads++;
        end else begin
            flag_fail("apb_bad_access");
        end
        if (!PSLVERR && err_rate && $urandom_range(0, 7) == 0) PSLVERR = 1'b1;
        if (PSLVERR) exp_err = 1;
    endtask

    // Accelerator slave on the falling edge, then scoreboard/monitor 2 ns later.
    initial forever begin
        @(negedge HCLK);
        if (HRESET) begin
            PREADY = 0; PSLVERR = 0; PRDATA = '0;
            acc_win[0] = '0; acc_win[1] = '0; acc_win[2] = '0; acc_w = '0;
            in_flight = 0; exp_err = 0; n_acc = 0; n_reads = 0; wait_left = 0;
            err_done = err_req; prev_stall = 0;
            s_q.delete(); hist.delete(); exp_q.delete();
        end else if (PSEL && !PENABLE) begin
            cap_addr = PADDR; cap_wdata = PWDATA; cap_write = PWRITE;
            PREADY = 0; PSLVERR = 0;
            if (hold_forever) wait_left = 1000000;
            else if (PWRITE && PADDR == 12'h000 && wr_wait_force >= 0) wait_left = wr_wait_force;
            else wait_left = $urandom_range(0, max_wait);
        end else if (PSEL && PENABLE) begin
            check("apb_paddr_stable", 32'(PADDR), 32'(cap_addr));
            check("apb_pwdata_stable", PWDATA, cap_wdata);
            check("apb_pwrite_stable", 32'(PWRITE), 32'(cap_write));
            if (wait_left > 0) begin
                wait_left--;
                PREADY = 0; PSLVERR = 0;
            end else begin
                PREADY = 1; PSLVERR = 0;
                apb_complete();
            end
        end else begin
            PREADY = 0; PSLVERR = 0;
        end
        #2;
        if (!HRESET) begin
            if (prev_stall) begin
                check("res_valid_held", 32'(res_valid_o), 32'd1);
                check("res_data_held", res_data_o, prev_data);
            end
            if (s_valid && s_ready_o) begin
                int unsigned e;
                s_q.push_back(s_data);
                hist.push_front(s_data);
                if (hist.size() > 3) void'(hist.pop_back());
                e = 0;
                for (int k = 0; k < hist.size(); k++)
                    e += ((int'(mw) >> (8 * (2 - k))) & 255) * int'(hist[k]);
                if (n_acc >= WARM) exp_q.push_back(e);
                n_acc++;
            end
            if (res_valid_o && res_ready) begin
                got_q.push_back(res_data_o);
                if (exp_q.size() == 0) flag_fail("result_unexpected");
                else check("result", res_data_o, exp_q.pop_front());
                in_flight = 0;
            end
            prev_stall = res_valid_o && !res_ready;
            prev_data  = res_data_o;
        end
    end

    initial forever begin
        @(posedge HCLK);
        #1;
        res_ready = rr_mode ? ($urandom_range(0, 3) != 0) : rr_fixed;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] x);
        int n = 0;
        s_valid = 1; s_data = x;
        @(negedge HCLK); #3;
        while (!s_ready_o && n < 400) begin
            @(negedge HCLK); #3;
            n++;
        end
        if (!s_ready_o) flag_fail("send_timeout");
        @(posedge HCLK); #1;
        s_valid = 0;
    endtask

    task automatic load_w(input logic [23:0] w);
        w_load = 1; w_data = w; mw = w;
        tick(1);
        w_load = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (n < 2000 && !(exp_q.size() == 0 && s_q.size() == 0 && !in_flight && !PSEL
                             && !res_valid_o)) begin
            tick(1);
            n++;
        end
        if (n >= 2000) flag_fail("drain_timeout");
        tick(3);
    endtask

    int base;
    int cbase;
    int ibase;

    initial begin
        HRESET = 1; s_valid = 0; s_data = '0; w_load = 0; w_data = '0;
        tick(3);
        check("rst_s_ready", 32'(s_ready_o), 32'd1);
        check("rst_res_valid", 32'(res_valid_o), 32'd0);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_res_data", res_data_o, 32'd0);
        HRESET = 0;
        tick(2);

        // Weight write then three samples; fresh window after reset.
        base = got_q.size(); cbase = cfg_writes;
        load_w(24'h030201);
        send(8'd10); send(8'd20); send(8'd30);
        drain();
        check("t2_cfg_count", 32'(cfg_writes - cbase), 32'd1);
`ifdef PSI_FEEDER_WARMUP_EN
        check("t2_result_count", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) check("t2_res_140", got_q[base], 32'd140);
`else
        check("t2_result_count", 32'(got_q.size() - base), 32'd3);
        if (got_q.size() >= base + 3) begin
            check("t2_res_30", got_q[base], 32'd30);
            check("t2_res_80", got_q[base+1], 32'd80);
            check("t2_res_140", got_q[base+2], 32'd140);
        end
`endif

        // Reset while stuck in the sample write access phase.
        hold_forever = 1;
        send(8'h55);
        begin
            int n = 0;
            while (n < 50 && !(PSEL && PENABLE && PWRITE && PADDR == 12'h000)) begin
                tick(1);
                n++;
            end
            if (n >= 50) flag_fail("wr_access_not_reached");
        end
        tick(2);
        HRESET = 1;
        #1;
        check("midrst_s_ready", 32'(s_ready_o), 32'd1);
        check("midrst_res_valid", 32'(res_valid_o), 32'd0);
        check("midrst_psel", 32'(PSEL), 32'd0);
        check("midrst_penable", 32'(PENABLE), 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        tick(1);
        HRESET = 0; hold_forever = 0; mw = '0;
        tick(5);
        check("midrst_no_traffic", 32'(PSEL), 32'd0);
        load_w(24'h010101);

        // Backpressure: one result held, FIFO fills, stream stalls.
        rr_fixed = 0;
        tick(1);
        base = got_q.size();
        for (int i = 0; i < 5 + WARM; i++) send(8'(i * 7 + 1));
        s_valid = 1; s_data = 8'd99;
        repeat (4) @(negedge HCLK);
        #3;
        check("bp_fifo_full_ready", 32'(s_ready_o), 32'd0);
        check("bp_res_valid", 32'(res_valid_o), 32'd1);
        @(posedge HCLK); #1;
        rr_fixed = 1;
        send(8'd99);
        drain();
        check("bp_result_count", 32'(got_q.size() - base), 32'd6);

        // Wait states during the sample write, plus a slave error.
        check("pre_err_clear", 32'(err_o), 32'd0);
        wr_wait_force = 3; err_req++;
        base = got_q.size(); ibase = inbuf_writes;
        send(8'h44);
        drain();
        wr_wait_force = -1;
        check("ws_single_write", 32'(inbuf_writes - ibase), 32'd1);
        check("ws_result_emitted", 32'(got_q.size() - base), 32'd1);
        check("err_sticky", 32'(err_o), 32'd1);
        check("err_model", 32'(err_o), 32'(exp_err));

        // Weight load while a sample is in flight.
        cbase = cfg_writes;
        send(8'h21);
        begin
            int n = 0;
            while (n < 50 && !in_flight) begin
                tick(1);
                n++;
            end
            if (n >= 50) flag_fail("in_flight_not_seen");
        end
        load_w(24'h050607);
        tick(3);
        send(8'h09);
        drain();
        check("t6_cfg_count", 32'(cfg_writes - cbase), 32'd1);

        // Random traffic with random ready, wait states and slave errors.
        rr_mode = 1; max_wait = 2; err_rate = 1;
        for (int b = 0; b < 4; b++) begin
            load_w(24'($urandom));
            for (int i = 0; i < 15; i++) begin
                send(8'($urandom_range(0, 255)));
                tick($urandom_range(0, 2));
            end
            drain();
        end
        rr_mode = 0; rr_fixed = 1; err_rate = 0; max_wait = 0;
        tick(2);
        check("final_err_model", 32'(err_o), 32'(exp_err));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
